week_bcd_counter: RTL and testbench
===================================

// Module: week_bcd_counter
// PURPOSE
//  Downstream stage of the mod-7 day counter. Consumes its one-cycle carry
//  pulse (one pulse per completed week) and counts weeks in a DIGITS-wide
//  BCD register for display. Provides preset load, hold, a sticky overflow
//  flag and a req/ack snapshot port so the readout logic can sample a
//  stable value while counting continues.
// PARAMETERS
//  DIGITS  4  number of BCD digits (1..8); count range 0 .. 10^DIGITS-1
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         synchronous reset, active-high
//  carry_in   in   1         week pulse from day counter, 1 = count one
//  clr        in   1         synchronous clear of count and ovf_flag
//  hold       in   1         1 = ignore carry_in (pulses dropped, not queued)
//  load       in   1         1 = load load_val into count
//  load_val   in   4*DIGITS  preset value, digit i at [4i+3:4i]
//  snap_req   in   1         request snapshot of current count
//  snap_ack   in   1         consumer has read snap_bcd
//  bcd        out  4*DIGITS  current count, registered
//  ovf_pulse  out  1         1-cycle pulse on wrap from all-9s to 0
//  ovf_flag   out  1         sticky overflow indicator
//  snap_bcd   out  4*DIGITS  captured count, stable while snap_valid
//  snap_valid out  1         snapshot available
// BEHAVIOUR
//  Reset (rst=1 at edge): bcd=0, ovf_pulse=0, ovf_flag=0, snap_bcd=0,
//   snap_valid=0, snapshot FSM -> IDLE. rst overrides every other input.
//  Count priority per edge: rst > clr > load > (carry_in & ~hold) > keep.
//  clr: bcd=0, ovf_flag=0, ovf_pulse=0. Snapshot state is unaffected.
//  load: each digit of load_val loaded; any digit >9 is clamped to 9.
//   load never sets ovf_pulse or ovf_flag.
//  Increment: digit 0 +1; a digit at 9 becomes 0 and carries to the next
//   digit. bcd updates on the same edge that samples carry_in (latency 1).
//   carry_in held high counts once per cycle.
//  Wrap: increment from all digits 9 -> bcd=0; ovf_pulse=1 on that same
//   edge for exactly one cycle; ovf_flag=1 until rst or clr.
//  ovf_pulse=0 in every cycle not produced by a wrap.
//  hold=1: carry_in ignored; clr and load still act.
//  Snapshot FSM, states IDLE / VALID:
//   IDLE : snap_req=1 -> snap_bcd <= bcd (value before this edge's update),
//          snap_valid <= 1, go VALID. snap_ack ignored in IDLE.
//   VALID: snap_bcd frozen; snap_req ignored. snap_ack=1 -> snap_valid <= 0,
//          go IDLE. snap_ack and snap_req together in VALID: ack wins,
//          request dropped. snap_bcd keeps its last value after ack.
//  All outputs are registered; no combinational path input -> output.
// TESTING
//  1. rst, then 9 carry_in pulses -> bcd=0x0009; 10th -> 0x0010;
//     100th -> 0x0100; ovf_pulse stays 0 throughout.
//  2. load 0x9999, then 1 carry -> bcd=0x0000, ovf_pulse=1 for one cycle,
//     ovf_flag=1; further carry -> 0x0001, ovf_flag still 1; clr -> flag 0.
//  3. hold=1 with 5 carries -> bcd unchanged; load 0x12A4 during hold
//     -> bcd=0x1294.
//  4. Same edge clr=1, load=1, carry_in=1 -> bcd=0x0000; load+carry_in
//     with load_val=0x0042 -> bcd=0x0042 (carry lost).
//  5. bcd=0x0037, snap_req + carry_in same edge -> snap_bcd=0x0037,
//     bcd=0x0038, snap_valid=1; further req and carries leave snap_bcd
//     unchanged; snap_ack -> snap_valid=0 next cycle.
//  6. rst asserted while snap_valid=1 and ovf_flag=1 -> all outputs 0 at
//     next edge; carry_in=1 continuously for 25 cycles -> bcd=0x0025.

Source files
------------

// File: rtl/week_bcd_counter.sv
// Week counter: counts carry pulses from the day counter in a DIGITS-wide BCD
// register. It supports preset load, hold, a sticky overflow flag and a
// req/ack snapshot port.
module week_bcd_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                carry_in,
    input  logic                clr,
    input  logic                hold,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                snap_req,
    input  logic                snap_ack,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf_pulse,
    output logic                ovf_flag,
    output logic [4*DIGITS-1:0] snap_bcd,
    output logic                snap_valid
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [0:0] {StIdle, StValid} snap_state_e;

    logic [W-1:0] bcd_q, bcd_d;
    logic         ovf_pulse_q, ovf_pulse_d;
    logic         ovf_flag_q, ovf_flag_d;
    logic [W-1:0] snap_bcd_q;
    logic [W-1:0] inc_val;
    logic         inc_wrap;
    logic [W-1:0] load_clamped;
    logic         snap_capture;
    snap_state_e  state_q, state_d;

    // Ripple +1 through the digits; inc_wrap is set when every digit was 9.
    always_comb begin
        logic [3:0] digit;
        logic       c;
        inc_val = '0;
        c       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = bcd_q[4*i +: 4];
            if (c) begin
                if (digit == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = digit + 4'd1;
                    c                 = 1'b0;
                end
            end else begin
                inc_val[4*i +: 4] = digit;
            end
        end
        inc_wrap = c;
    end

    // Clamp each preset digit to 9 so the register never holds a non-BCD code.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Count next state: clr > load > increment > keep.
    always_comb begin
        bcd_d       = bcd_q;
        ovf_pulse_d = 1'b0;
        ovf_flag_d  = ovf_flag_q;
        if (clr) begin
            bcd_d      = '0;
            ovf_flag_d = 1'b0;
        end else if (load) begin
            bcd_d = load_clamped;
        end else if (carry_in && !hold) begin
            bcd_d = inc_val;
            if (inc_wrap) begin
                ovf_pulse_d = 1'b1;
                ovf_flag_d  = 1'b1;
            end
        end
    end

    // Count and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q       <= '0;
            ovf_pulse_q <= 1'b0;
            ovf_flag_q  <= 1'b0;
        end else begin
            bcd_q       <= bcd_d;
            ovf_pulse_q <= ovf_pulse_d;
            ovf_flag_q  <= ovf_flag_d;
        end
    end

    // Snapshot state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshot next state; in VALID an ack wins over a simultaneous request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (snap_req) state_d = StValid;
            StValid: if (snap_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Snapshot outputs: capture strobe and valid decode from the state register.
    always_comb begin
        snap_capture = (state_q == StIdle) && snap_req;
        snap_valid   = (state_q == StValid);
    end

    // Snapshot data captures the pre-update count and holds it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_bcd_q <= '0;
        end else if (snap_capture) begin
            snap_bcd_q <= bcd_q;
        end
    end

    assign bcd       = bcd_q;
    assign ovf_pulse = ovf_pulse_q;
    assign ovf_flag  = ovf_flag_q;
    assign snap_bcd  = snap_bcd_q;

endmodule

// File: tb/tb_week_bcd_counter.sv
// Bench for week_bcd_counter: directed scenarios plus random traffic, with a
// cycle-by-cycle comparison against an integer-valued reference model.
module tb_week_bcd_counter;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;
    localparam int          MODV   = 10000;

    logic         clk = 1'b0;
    logic         rst, carry_in, clr, hold, load, snap_req, snap_ack;
    logic [W-1:0] load_val;
    logic [W-1:0] bcd, snap_bcd;
    logic         ovf_pulse, ovf_flag, snap_valid;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state, kept as plain integers.
    int m_val;
    bit m_pulse, m_flag, m_sv;
    int m_snap;

    week_bcd_counter #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (carry_in),
        .clr       (clr),
        .hold      (hold),
        .load      (load),
        .load_val  (load_val),
        .snap_req  (snap_req),
        .snap_ack  (snap_ack),
        .bcd       (bcd),
        .ovf_pulse (ovf_pulse),
        .ovf_flag  (ovf_flag),
        .snap_bcd  (snap_bcd),
        .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    // Preset value as an integer, each digit clamped to 9.
    function automatic int load_to_int(input logic [W-1:0] lv);
        int v;
        int p;
        int d;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic model_edge();
        int old_val;
        old_val = m_val;
        if (rst) begin
            m_val = 0; m_pulse = 0; m_flag = 0; m_sv = 0; m_snap = 0;
        end else begin
            if (!m_sv && snap_req) begin
                m_snap = old_val;
                m_sv   = 1;
            end else if (m_sv && snap_ack) begin
                m_sv = 0;
            end
            m_pulse = 0;
            if (clr) begin
                m_val  = 0;
                m_flag = 0;
            end else if (load) begin
                m_val = load_to_int(load_val);
            end else if (carry_in && !hold) begin
                m_val = old_val + 1;
                if (m_val == MODV) begin
                    m_val   = 0;
                    m_pulse = 1;
                    m_flag  = 1;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        rst = 0; carry_in = 0; clr = 0; hold = 0; load = 0;
        snap_req = 0; snap_ack = 0; load_val = '0;
    endtask

    // One clock: inputs already driven, advance model on the edge, settle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("bcd", bcd, to_bcd(m_val));
            check("ovf_pulse", W'(ovf_pulse), W'(m_pulse));
            check("ovf_flag", W'(ovf_flag), W'(m_flag));
            check("snap_valid", W'(snap_valid), W'(m_sv));
            check("snap_bcd", snap_bcd, to_bcd(m_snap));
        end
    end

    initial begin
        idle_inputs();
        m_val = 0; m_pulse = 0; m_flag = 0; m_sv = 0; m_snap = 0;
        rst = 1;
        tick();
        tick();
        cmp_en = 1'b1;
        check("reset_bcd", bcd, 16'h0000);
        check("reset_snap_valid", W'(snap_valid), 16'h0000);
        rst = 0;

        // 1: decimal carries across digits
        carry_in = 1;
        for (int i = 0; i < 9; i++) tick();
        check("t1_nine", bcd, 16'h0009);
        tick();
        check("t1_ten", bcd, 16'h0010);
        for (int i = 0; i < 90; i++) tick();
        check("t1_hundred", bcd, 16'h0100);
        check("t1_no_pulse", W'(ovf_pulse), 16'h0000);
        carry_in = 0;

        // 2: wrap from all nines
        load = 1; load_val = 16'h9999; tick(); load = 0;
        carry_in = 1; tick(); carry_in = 0;
        check("t2_wrap_bcd", bcd, 16'h0000);
        check("t2_wrap_pulse", W'(ovf_pulse), 16'h0001);
        check("t2_wrap_flag", W'(ovf_flag), 16'h0001);
        carry_in = 1; tick(); carry_in = 0;
        check("t2_after_bcd", bcd, 16'h0001);
        check("t2_pulse_gone", W'(ovf_pulse), 16'h0000);
        check("t2_flag_sticky", W'(ovf_flag), 16'h0001);
        clr = 1; tick(); clr = 0;
        check("t2_clr_flag", W'(ovf_flag), 16'h0000);

        // 3: hold drops pulses, load still acts and clamps
        hold = 1; carry_in = 1;
        for (int i = 0; i < 5; i++) tick();
        check("t3_hold", bcd, 16'h0000);
        carry_in = 0; load = 1; load_val = 16'h12A4; tick(); load = 0; hold = 0;
        check("t3_clamp", bcd, 16'h1294);

        // 4: priority clr > load > carry
        clr = 1; load = 1; carry_in = 1; load_val = 16'h5555; tick();
        check("t4_clr_wins", bcd, 16'h0000);
        clr = 0; load_val = 16'h0042; tick(); load = 0; carry_in = 0;
        check("t4_load_wins", bcd, 16'h0042);

        // 5: snapshot captures pre-update value and freezes
        load = 1; load_val = 16'h0037; tick(); load = 0;
        snap_req = 1; carry_in = 1; tick();
        check("t5_snap", snap_bcd, 16'h0037);
        check("t5_bcd", bcd, 16'h0038);
        check("t5_valid", W'(snap_valid), 16'h0001);
        for (int i = 0; i < 3; i++) tick();
        check("t5_frozen", snap_bcd, 16'h0037);
        snap_req = 1; snap_ack = 1; carry_in = 0; tick(); snap_ack = 0; snap_req = 0;
        check("t5_ack", W'(snap_valid), 16'h0000);
        check("t5_keep", snap_bcd, 16'h0037);

        // 6: reset with valid snapshot and sticky flag
        load = 1; load_val = 16'h9999; tick(); load = 0;
        carry_in = 1; snap_req = 1; tick(); carry_in = 0; snap_req = 0;
        rst = 1; tick(); rst = 0;
        check("t6_rst_bcd", bcd, 16'h0000);
        check("t6_rst_flag", W'(ovf_flag), 16'h0000);
        check("t6_rst_valid", W'(snap_valid), 16'h0000);
        check("t6_rst_snap", snap_bcd, 16'h0000);
        carry_in = 1;
        for (int i = 0; i < 25; i++) tick();
        carry_in = 0;
        check("t6_count25", bcd, 16'h0025);

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            clr      = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 11) == 0);
            load_val = ($urandom_range(0, 1) == 0) ? 16'($urandom) : {12'h999, 4'($urandom)};
            carry_in = ($urandom_range(0, 3) != 0);
            hold     = ($urandom_range(0, 4) == 0);
            snap_req = ($urandom_range(0, 3) == 0);
            snap_ack = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle_inputs();
        tick();
        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
